alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 96 +++++++++
 tb/tb_alu_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: collects A, B and opcode bytes, drives an external ALU, returns its result.
// Optional opcode validation with ALU_SEQUENCER_OPCHECK_EN.
module alu_sequencer #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [BITS_DATA-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic [BITS_DATA-1:0] o_alu_a,
  output logic [BITS_DATA-1:0] o_alu_b,
  output logic [BITS_OP-1:0]   o_alu_op,
  input  logic [BITS_DATA-1:0] i_alu_result,
  output logic [BITS_DATA-1:0] o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_err
);
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;
  state_t               r_state;
  logic [BITS_DATA-1:0] r_alu_a, r_alu_b, r_tx_data;
  logic [BITS_OP-1:0]   r_alu_op;
  logic                 r_rx_ready, r_tx_valid, r_busy, r_err;
  logic                 w_rx_fire, w_op_ok;
  logic [BITS_OP-1:0]   w_op;
  assign w_rx_fire = i_rx_valid & r_rx_ready;
  assign w_op      = i_rx_data[BITS_OP-1:0];
`ifdef ALU_SEQUENCER_OPCHECK_EN
  assign w_op_ok = (w_op == BITS_OP'(8'h20)) || (w_op == BITS_OP'(8'h22)) ||
                   (w_op == BITS_OP'(8'h24)) || (w_op == BITS_OP'(8'h25)) ||
                   (w_op == BITS_OP'(8'h26)) || (w_op == BITS_OP'(8'h03)) ||
                   (w_op == BITS_OP'(8'h02)) || (w_op == BITS_OP'(8'h27));
`else
  assign w_op_ok = 1'b1;
`endif
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= GET_A;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        GET_A: if (w_rx_fire) begin
          r_alu_a <= i_rx_data;
          r_busy  <= 1'b1;
          r_state <= GET_B;
        end
        GET_B: if (w_rx_fire) begin
          r_alu_b <= i_rx_data;
          r_state <= GET_OP;
        end
        GET_OP: if (w_rx_fire) begin
          if (w_op_ok) begin
            r_alu_op   <= w_op;
            r_rx_ready <= 1'b0;
            r_state    <= EXEC;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= GET_A;
          end
        end
        EXEC: begin
          r_tx_data  <= i_alu_result;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
        SEND: if (i_tx_ready) begin
          r_tx_valid <= 1'b0;
          r_rx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= GET_A;
        end
        default: r_state <= GET_A;
      endcase
    end
  end
  assign o_rx_ready = r_rx_ready;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_err      = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized frames against a behavioural ALU/sequencer model.
module tb_alu_sequencer;
  logic       clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic       rx_valid = 0, tx_ready = 0;
  logic       rx_ready, tx_valid, busy, err;
  logic [7:0] alu_a, alu_b, alu_res, tx_data;
  logic [5:0] alu_op;
  logic [5:0] last_op = 0;
  logic [7:0] last_tx = 0;
  logic [5:0] codes [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
  int n_vec = 0, n_err = 0, n_tx = 0, n_tx_exp = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.BITS_DATA(8), .BITS_OP(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_res), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready), .o_busy(busy), .o_err(err)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h03: return 8'($signed(a) >>> b[2:0]);
      6'h02: return a >> b[2:0];
      6'h27: return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
`ifdef ALU_SEQUENCER_OPCHECK_EN
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
`else
    return 1'b1;
`endif
  endfunction

  assign alu_res = alu_fn(alu_a, alu_b, alu_op);

  always @(posedge clk) if (tx_valid && tx_ready) n_tx++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = d;
    rx_valid = 1;
    check("rx_ready_get", rx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 0;
    rx_data  = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap, input int delay);
    logic [5:0] op6;
    logic [7:0] exp;
    op6 = op[5:0];
    send_byte(a, gap);
    check("busy_after_a", busy, 1);
    send_byte(b, gap);
    tx_ready = (delay == 0);
    send_byte(op, gap);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    if (!op_legal(op6)) begin
      check("err_pulse", err, 1);
      check("tx_valid_bad_op", tx_valid, 0);
      check("busy_bad_op", busy, 0);
      check("rx_ready_bad_op", rx_ready, 1);
      check("alu_op_kept", alu_op, last_op);
      check("tx_data_kept", tx_data, last_tx);
      @(negedge clk);
      check("err_one_cycle", err, 0);
      check("tx_valid_after_bad", tx_valid, 0);
      tx_ready = 0;
      return;
    end
    check("alu_op", alu_op, op6);
    check("tx_valid_exec", tx_valid, 0);
    check("rx_ready_exec", rx_ready, 0);
    check("err_quiet", err, 0);
    exp = alu_fn(a, b, op6);
    @(negedge clk);
    check("tx_valid", tx_valid, 1);
    check("tx_data", tx_data, exp);
    check("rx_ready_send", rx_ready, 0);
    check("busy_send", busy, 1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("tx_valid_hold", tx_valid, 1);
      check("tx_data_hold", tx_data, exp);
      check("rx_ready_hold", rx_ready, 0);
    end
    tx_ready = 1;
    @(negedge clk);
    check("tx_valid_clear", tx_valid, 0);
    check("rx_ready_back", rx_ready, 1);
    check("busy_idle", busy, 0);
    tx_ready = 0;
    last_op = op6;
    last_tx = exp;
    n_tx_exp++;
  endtask

  initial begin
    #12;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_err", err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 0;
    run_frame(8'h05, 8'h03, 8'h20, 0, 0);
    check("add_result", tx_data, 8'h08);
    run_frame(8'h03, 8'h05, 8'h22, 0, 1);
    check("sub_result", tx_data, 8'hFE);
    run_frame(8'h0F, 8'hF0, 8'h27, 1, 0);
    check("nor_result", tx_data, 8'h00);
    run_frame(8'h81, 8'h02, 8'h03, 0, 4);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1;
    #1;
    check("arst_rx_ready", rx_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 0;
    last_op = 0;
    last_tx = 0;
    repeat (3) begin
      @(negedge clk);
      check("no_tx_after_rst", tx_valid, 0);
    end
    run_frame(8'h01, 8'h01, 8'h20, 0, 0);
    check("post_rst_result", tx_data, 8'h02);
    run_frame(8'($urandom), 8'($urandom), 8'h3F, 0, 0);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 5) == 0) ? 8'($urandom) : {2'($urandom), codes[$urandom_range(0, 7)]};
      run_frame(8'($urandom), 8'($urandom), op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (2) @(negedge clk);
    check("result_count", n_tx, n_tx_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
